// File: rtl/arb_mux_n_pkg.sv
// Shared definitions for the N-input arbitrated mux:
// selection mode encodings and a constant clog2 helper.
package arb_mux_n_pkg;

  localparam int MUX_MODE_EXT  = 0;
  localparam int MUX_MODE_PRIO = 1;
  localparam int MUX_MODE_RR   = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_mux_n_rr_arbiter.sv
// Rotating-priority arbiter: first request at or after ptr_i,
// wrapping modulo NUM_IN. A zero pointer gives fixed priority.
module rr_arbiter #(
  parameter int NUM_IN = 2,
  parameter int SEL_W  = 1
) (
  input  logic [NUM_IN-1:0] req_i,
  input  logic [SEL_W-1:0]  ptr_i,
  output logic [NUM_IN-1:0] gnt_o,
  output logic [SEL_W-1:0]  idx_o
);

  int               j;
  logic [SEL_W-1:0] jj;
  logic             found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    jj    = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NUM_IN) j = j - NUM_IN;
      jj = SEL_W'(j);
      if (!found && req_i[jj]) begin
        found     = 1'b1;
        gnt_o[jj] = 1'b1;
        idx_o     = jj;
      end
    end
  end

endmodule

// File: rtl/arb_mux_n.sv
// Registered N:1 mux with valid/ready channels and a one-entry
// output buffer; external, fixed-priority or round-robin select.
module arb_mux_n
  import arb_mux_n_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int NUM_IN = 2,
  parameter int MODE   = MUX_MODE_EXT,
  localparam int SEL_W =
    (clog2(NUM_IN) > 1) ? clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_src
);

  logic [WIDTH-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic [SEL_W-1:0]  src_q, src_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;

  logic              can_load;
  logic              xfer;
  logic [NUM_IN-1:0] arb_gnt, gnt;
  logic [SEL_W-1:0]  arb_idx, gnt_idx;
  logic [SEL_W-1:0]  arb_ptr;
  logic [WIDTH-1:0]  word;

  assign arb_ptr = (MODE == MUX_MODE_RR) ? ptr_q : '0;

  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_arb (
    .req_i  (in_valid),
    .ptr_i  (arb_ptr),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx)
  );

  always_comb begin
    gnt     = arb_gnt;
    gnt_idx = arb_idx;
    if (MODE == MUX_MODE_EXT) begin
      gnt     = '0;
      gnt_idx = '0;
      // Out-of-range select grants nothing.
      if (int'(sel) < NUM_IN) begin
        gnt[sel] = in_valid[sel];
        gnt_idx  = sel;
      end
    end
  end

  assign can_load = ~valid_q | out_ready;
  assign in_ready = gnt & {NUM_IN{can_load & rst_n}};
  assign xfer     = |in_ready;
  assign word     = in_data[gnt_idx*WIDTH +: WIDTH];

  always_comb begin
    data_d  = data_q;
    src_d   = src_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      data_d  = word;
      src_d   = gnt_idx;
      valid_d = 1'b1;
      if (MODE == MUX_MODE_RR) begin
        ptr_d = (int'(gnt_idx) == NUM_IN - 1)
              ? '0 : gnt_idx + SEL_W'(1);
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      src_q   <= '0;
      ptr_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_src   = src_q;

endmodule
